median_stream_filter: RTL and testbench
=======================================

MEDIAN_STREAM_FILTER -- requirements
Module: median_stream_filter

Interface
REQ-001 Parameter DATA_W, default 8, pixel width in bits.
REQ-002 Parameter IMG_W, default 512, pixels per row (>=3).
REQ-003 Parameter IMG_H, default 512, rows per frame (>=3).
REQ-004 Parameter BORDER, default 0, border mode: 0 = border outputs forced to 0; 1 = border outputs equal the unfiltered centre pixel.
REQ-005 CLK  input  1  single clock; all state changes on rising edge.
REQ-006 RST  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  in_data holds a pixel.
REQ-008 in_ready  output  1  block accepts a pixel this cycle.
REQ-009 in_data  input  DATA_W  raster-order pixel, row 0 col 0 first.
REQ-010 out_valid  output  1  out_data holds a filtered pixel, one-cycle pulse per pixel, no backpressure.
REQ-011 out_data  output  DATA_W  filtered pixel, raster order.
REQ-012 out_eof  output  1  high with out_valid on the last pixel (IMG_W*IMG_H-1) of a frame.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 A pixel shall be accepted exactly on cycles where in_valid && in_ready.
REQ-015 Two line buffers, IMG_W deep x DATA_W, plus a 3x3 window register shall hold the neighbourhood; the window shall shift only on accept or flush cycles, never on bubbles.
REQ-016 Output pixel j (centre) shall become computable on the shift cycle that consumes input j+IMG_W+1 (or equivalent flush cycle).
REQ-017 Interior output shall be the exact median (5th of 9, ties allowed) of the 3x3 neighbourhood, computed in a 3-stage registered compare-exchange network.
REQ-018 out_valid for pixel j shall assert exactly 3 cycles after the shift cycle of REQ-016.
REQ-019 Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) shall follow BORDER and pass through the same 3-cycle pipeline.
REQ-020 Exactly IMG_W*IMG_H outputs per frame, in raster order; none for the first IMG_W+1 shift cycles.
REQ-021 States: IDLE, RUN, FLUSH, DRAIN.
REQ-022 IDLE: in_ready=1; first accept -> RUN.
REQ-023 RUN: in_ready=1; accept of pixel IMG_W*IMG_H-1 -> FLUSH.
REQ-024 FLUSH: in_ready=0; IMG_W+1 consecutive internal shift cycles with dummy data, then -> DRAIN.
REQ-025 DRAIN: in_ready=0; 3 cycles, out_eof fires on the last one, then -> IDLE.
REQ-026 in_ready shall be low for exactly IMG_W+4 cycles after the frame's last accept; the next frame may start on the following cycle.
REQ-027 Row/column counters shall wrap at IMG_W-1 / IMG_H-1 without overflow; widths = clog2 of each dimension.
REQ-028 Bubbles (in_valid=0) in IDLE/RUN shall not alter output values or order, only timing.

Reset
REQ-029 While RST=1: state IDLE, counters 0, in_ready=0, out_valid=0, out_data=0, out_eof=0, busy=0, pipeline valids cleared.
REQ-030 Cycle after RST deasserts: in_ready=1.
REQ-031 Line-buffer contents need not be cleared; border masking guarantees no stale data reaches an output.
REQ-032 RST mid-frame shall abandon the frame: no further out_valid from it; the next frame processes correctly from pixel 0.

Verification (IMG_W=8, IMG_H=6, DATA_W=8)
REQ-033 Constant 0x40 frame, BORDER=1 -> 48 outputs all 0x40; BORDER=0 -> 24 interior 0x40, 24 border 0x00.
REQ-034 Zero frame with single 0xFF at row 2 col 3, BORDER=0 -> all 48 outputs 0x00 (impulse removed).
REQ-035 Neighbourhood of (2,2) = values 9,8,...,1, rest 0 -> output pixel 18 = 0x05.
REQ-036 Random frame fed with random in_valid bubbles -> output sequence identical to bubble-free run, exactly 48 out_valid, out_eof only on 48th.
REQ-037 RST asserted after 20 accepts -> no out_valid until a new frame; next full frame matches golden model.
REQ-038 Back-to-back frames with in_valid held high -> in_ready low exactly 12 cycles between frames; out_eof 3 cycles after final flush cycle.

Source files
------------

// File: rtl/median_stream_filter.sv
// median_stream_filter: streaming 3x3 median filter over raster-order frames.
// Two line buffers plus a 3x3 window feed a three-stage registered
// compare-exchange network. Border pixels are either zeroed or passed through.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for the first pixel of a frame, in_ready high
// RUN   | accepting pixels of the frame, in_ready high
// FLUSH | IMG_W+1 internal shifts of dummy data to push out the last rows
// DRAIN | 3 cycles letting the median pipeline empty, eof on the last one
module median_stream_filter #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int BORDER = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_eof,
    output logic              busy
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int PW = $clog2(IMG_W + 2);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [PW-1:0] PRIME_LAST = PW'(IMG_W + 1);
    localparam logic [PW-1:0] FLUSH_LOAD = PW'(IMG_W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DRAIN} state_t;

    function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [DATA_W-1:0] min3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        return min2(min2(a, b), c);
    endfunction

    function automatic logic [DATA_W-1:0] max3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        return max2(max2(a, b), c);
    endfunction

    function automatic logic [DATA_W-1:0] med3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    state_t          state_q, state_d;
    logic [PW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [1:0]      drain_cnt_q, drain_cnt_d;
    logic [CW-1:0]   in_col_q, in_col_d;
    logic [RW-1:0]   in_row_q, in_row_d;
    logic [PW-1:0]   prime_q, prime_d;
    logic [CW-1:0]   ctr_col_q, ctr_col_d;
    logic [RW-1:0]   ctr_row_q, ctr_row_d;

    logic            accept, shift, emit, last_in;
    logic            ctr_border, ctr_eof;
    logic [DATA_W-1:0] pix_new, col_top, col_mid;

    logic [DATA_W-1:0] lb0_q [IMG_W];
    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] win_q [3][3];
    logic [DATA_W-1:0] win_d [3][3];

    logic [DATA_W-1:0] s1_lo_q [3];
    logic [DATA_W-1:0] s1_mid_q [3];
    logic [DATA_W-1:0] s1_hi_q [3];
    logic [DATA_W-1:0] s1_ctr_q, s2_ctr_q;
    logic              s1_border_q, s2_border_q, s1_eof_q, s2_eof_q;
    logic [DATA_W-1:0] s2_a_q, s2_b_q, s2_c_q;
    logic              s1_vld_q, s2_vld_q, out_vld_q, out_eof_q;
    logic [DATA_W-1:0] out_data_q, border_val;

    assign accept  = in_valid && in_ready;
    assign shift   = accept || (!RST && (state_q == S_FLUSH));
    assign emit    = (prime_q == PRIME_LAST);
    assign last_in = (in_col_q == COL_LAST) && (in_row_q == ROW_LAST);

    // Flush shifts feed zeros; any window touching them is centred on a border pixel.
    assign pix_new = (state_q == S_FLUSH) ? '0 : in_data;
    assign col_top = lb1_q[in_col_q];
    assign col_mid = lb0_q[in_col_q];

    assign ctr_border = (ctr_row_q == '0) || (ctr_row_q == ROW_LAST) ||
                        (ctr_col_q == '0) || (ctr_col_q == COL_LAST);
    assign ctr_eof    = (ctr_row_q == ROW_LAST) && (ctr_col_q == COL_LAST);

    // FSM next-state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        drain_cnt_d = drain_cnt_q;
        in_ready    = 1'b0;
        busy        = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = !RST;
                if (in_valid) state_d = S_RUN;
            end
            S_RUN: begin
                in_ready = !RST;
                busy     = !RST;
                if (in_valid && last_in) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end
            S_FLUSH: begin
                busy = !RST;
                if (flush_cnt_q == '0) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = 2'd2;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            S_DRAIN: begin
                busy = !RST;
                if (drain_cnt_q == '0) state_d = S_IDLE;
                else drain_cnt_d = drain_cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Input position, priming count and output-centre position advance per shift.
    always_comb begin
        in_col_d  = in_col_q;
        in_row_d  = in_row_q;
        prime_d   = prime_q;
        ctr_col_d = ctr_col_q;
        ctr_row_d = ctr_row_q;
        if (state_q == S_DRAIN) begin
            in_col_d  = '0;
            in_row_d  = '0;
            prime_d   = '0;
            ctr_col_d = '0;
            ctr_row_d = '0;
        end else if (shift) begin
            if (in_col_q == COL_LAST) begin
                in_col_d = '0;
                in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + 1'b1;
            end else begin
                in_col_d = in_col_q + 1'b1;
            end
            if (!emit) begin
                prime_d = prime_q + 1'b1;
            end else if (ctr_col_q == COL_LAST) begin
                ctr_col_d = '0;
                ctr_row_d = (ctr_row_q == ROW_LAST) ? '0 : ctr_row_q + 1'b1;
            end else begin
                ctr_col_d = ctr_col_q + 1'b1;
            end
        end
    end

    // Control state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= '0;
            drain_cnt_q <= '0;
            in_col_q    <= '0;
            in_row_q    <= '0;
            prime_q     <= '0;
            ctr_col_q   <= '0;
            ctr_row_q   <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            in_col_q    <= in_col_d;
            in_row_q    <= in_row_d;
            prime_q     <= prime_d;
            ctr_col_q   <= ctr_col_d;
            ctr_row_q   <= ctr_row_d;
        end
    end

    // Next window: drop the oldest column, append {row-2, row-1, new pixel}.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 3; r++) begin
                win_d[c][r] = win_q[c+1][r];
            end
        end
        win_d[2][0] = col_top;
        win_d[2][1] = col_mid;
        win_d[2][2] = pix_new;
    end

    // Line buffers and window move only on shift cycles; no reset needed.
    always_ff @(posedge CLK) begin
        if (shift) begin
            lb0_q[in_col_q] <= pix_new;
            lb1_q[in_col_q] <= col_mid;
            win_q           <= win_d;
        end
    end

    // Median network data path: sort columns, reduce, final median of three.
    always_ff @(posedge CLK) begin
        for (int c = 0; c < 3; c++) begin
            s1_lo_q[c]  <= min3(win_d[c][0], win_d[c][1], win_d[c][2]);
            s1_mid_q[c] <= med3(win_d[c][0], win_d[c][1], win_d[c][2]);
            s1_hi_q[c]  <= max3(win_d[c][0], win_d[c][1], win_d[c][2]);
        end
        s1_ctr_q    <= win_d[1][1];
        s1_border_q <= ctr_border;
        s1_eof_q    <= ctr_eof;
        s2_a_q      <= max3(s1_lo_q[0], s1_lo_q[1], s1_lo_q[2]);
        s2_b_q      <= med3(s1_mid_q[0], s1_mid_q[1], s1_mid_q[2]);
        s2_c_q      <= min3(s1_hi_q[0], s1_hi_q[1], s1_hi_q[2]);
        s2_ctr_q    <= s1_ctr_q;
        s2_border_q <= s1_border_q;
        s2_eof_q    <= s1_eof_q;
    end

    assign border_val = (BORDER != 0) ? s2_ctr_q : '0;

    // Pipeline valids and the output register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_eof_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            s1_vld_q  <= shift && emit;
            s2_vld_q  <= s1_vld_q;
            out_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                out_eof_q  <= s2_eof_q;
                out_data_q <= s2_border_q ? border_val : med3(s2_a_q, s2_b_q, s2_c_q);
            end
        end
    end

    assign out_valid = out_vld_q && !RST;
    assign out_eof   = out_vld_q && out_eof_q && !RST;
    assign out_data  = RST ? '0 : out_data_q;

endmodule

// File: tb/tb_median_stream_filter.sv
// tb_median_stream_filter: drives random and directed frames into two filters
// (zeroed and passed-through borders) and compares against a sorting model.
module tb_median_stream_filter;
    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic       CLK = 1'b0;
    logic       RST;
    logic       in_valid;
    logic [7:0] in_data;
    logic       rdy0, vld0, eof0, busy0;
    logic       rdy1, vld1, eof1, busy1;
    logic [7:0] dat0, dat1;

    median_stream_filter #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .BORDER(0)) dut0 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .out_valid(vld0), .out_data(dat0), .out_eof(eof0), .busy(busy0));

    median_stream_filter #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .BORDER(1)) dut1 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(vld1), .out_data(dat1), .out_eof(eof1), .busy(busy1));

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    logic [7:0] img [N];
    int         exp0 [N];
    int         exp1 [N];

    // Reference: explicit border rule, otherwise sort the 3x3 neighbourhood.
    function automatic void build_model();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int p;
                int v [9];
                int k;
                int key;
                int j;
                p = r * W + c;
                if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
                    exp0[p] = 0;
                    exp1[p] = int'(img[p]);
                end else begin
                    k = 0;
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++) begin
                            v[k] = int'(img[(r + dr) * W + c + dc]);
                            k++;
                        end
                    for (int i = 1; i < 9; i++) begin
                        key = v[i];
                        j = i - 1;
                        while (j >= 0 && v[j] > key) begin
                            v[j + 1] = v[j];
                            j--;
                        end
                        v[j + 1] = key;
                    end
                    exp0[p] = v[4];
                    exp1[p] = v[4];
                end
            end
        end
    endfunction

    logic [7:0] cap0 [4096];
    logic [7:0] cap1 [4096];
    logic       ceof0 [4096];
    logic       ceof1 [4096];
    int cnt0 = 0, cnt1 = 0;
    int cyc = 0;
    int acc_idx = 0, oif = 0, t9 = 0, last_acc = 0, lat = -1, gap = -1;

    always @(posedge CLK) cyc <= cyc + 1;

    // Capture outputs and record latency markers, sampled mid-cycle.
    always @(negedge CLK) begin
        if (RST) begin
            acc_idx = 0;
            oif = 0;
        end else begin
            if (in_valid && rdy0) begin
                if (acc_idx == W + 1) t9 = cyc;
                if (acc_idx == N - 1) begin
                    last_acc = cyc;
                    acc_idx = 0;
                end else acc_idx++;
            end
            if (vld0 && cnt0 < 4096) begin
                cap0[cnt0] = dat0;
                ceof0[cnt0] = eof0;
                cnt0++;
                if (oif == 0) lat = cyc - t9;
                if (eof0) begin
                    gap = cyc - last_acc;
                    oif = 0;
                end else oif++;
            end
            if (vld1 && cnt1 < 4096) begin
                cap1[cnt1] = dat1;
                ceof1[cnt1] = eof1;
                cnt1++;
            end
        end
    end

    task automatic send_frame(input int npix, input int bub, input bit hold, output int first_wait);
        int w;
        int nb;
        bit tout;
        tout = 1'b0;
        first_wait = 0;
        for (int i = 0; i < npix; i++) begin
            nb = 0;
            while (bub > 0 && nb < 4 && $urandom_range(99) < bub) begin
                in_valid = 1'b0;
                @(posedge CLK); #1;
                nb++;
            end
            in_valid = 1'b1;
            in_data  = img[i];
            w = 0;
            while (!rdy0 && w < 100) begin
                @(posedge CLK); #1;
                w++;
            end
            if (w >= 100) tout = 1'b1;
            if (i == 0) first_wait = w;
            @(posedge CLK); #1;
        end
        if (!hold) in_valid = 1'b0;
        chk("ready_timeout", int'(tout), 0);
    endtask

    task automatic verify(input string tag, input int base, input int nf);
        int w;
        int ne0;
        int ne1;
        int idx;
        w = 0;
        ne0 = 0;
        ne1 = 0;
        while ((busy0 || busy1) && w < 400) begin
            @(posedge CLK);
            w++;
        end
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        chk({tag, "_idle"}, int'(busy0 || busy1), 0);
        chk({tag, "_cnt0"}, cnt0 - base, N * nf);
        chk({tag, "_cnt1"}, cnt1 - base, N * nf);
        for (int f = 0; f < nf; f++) begin
            for (int i = 0; i < N; i++) begin
                idx = base + f * N + i;
                chk($sformatf("%s_b0_px%0d", tag, i), int'(cap0[idx]), exp0[i]);
                chk($sformatf("%s_b1_px%0d", tag, i), int'(cap1[idx]), exp1[i]);
                if (ceof0[idx]) ne0++;
                if (ceof1[idx]) ne1++;
            end
            chk({tag, "_eof_last"}, int'(ceof0[base + f * N + N - 1]), 1);
        end
        chk({tag, "_eof_count0"}, ne0, nf);
        chk({tag, "_eof_count1"}, ne1, nf);
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_eof_gap"}, gap, W + 4);
        @(posedge CLK); #1;
    endtask

    initial begin
        int base;
        int fw;
        int cnt;
        int snap;
        RST = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ready0", int'(rdy0), 0);
        chk("rst_ready1", int'(rdy1), 0);
        chk("rst_valid", int'(vld0), 0);
        chk("rst_data", int'(dat0), 0);
        chk("rst_eof", int'(eof0), 0);
        chk("rst_busy", int'(busy0), 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_rst", int'(rdy0), 1);
        chk("busy_after_rst", int'(busy0), 0);
        @(posedge CLK); #1;

        for (int i = 0; i < N; i++) img[i] = 8'h40;
        build_model();
        base = cnt0;
        send_frame(N, 0, 1'b0, fw);
        verify("const", base, 1);
        cnt = 0;
        for (int i = 0; i < N; i++) if (cap0[base + i] == 8'h40) cnt++;
        chk("const_b0_interior", cnt, 24);
        cnt = 0;
        for (int i = 0; i < N; i++) if (cap1[base + i] == 8'h40) cnt++;
        chk("const_b1_all", cnt, 48);

        for (int i = 0; i < N; i++) img[i] = 8'h00;
        img[2 * W + 3] = 8'hFF;
        build_model();
        base = cnt0;
        send_frame(N, 0, 1'b0, fw);
        verify("impulse", base, 1);
        cnt = 0;
        for (int i = 0; i < N; i++) if (cap0[base + i] != 8'h00) cnt++;
        chk("impulse_nonzero", cnt, 0);

        for (int i = 0; i < N; i++) img[i] = 8'h00;
        for (int k = 0; k < 9; k++) img[(1 + k / 3) * W + 1 + k % 3] = 8'(9 - k);
        build_model();
        base = cnt0;
        send_frame(N, 0, 1'b0, fw);
        verify("nbhd", base, 1);
        chk("nbhd_px18", int'(cap0[base + 18]), 5);

        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(255));
        build_model();
        base = cnt0;
        send_frame(N, 0, 1'b0, fw);
        verify("rand", base, 1);
        base = cnt0;
        send_frame(N, 35, 1'b0, fw);
        verify("rand_bubbles", base, 1);

        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(255));
        send_frame(20, 0, 1'b0, fw);
        RST = 1'b1;
        @(negedge CLK);
        snap = cnt0;
        chk("mid_rst_valid", int'(vld0), 0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        repeat (30) @(posedge CLK);
        @(negedge CLK);
        chk("mid_rst_quiet", cnt0 - snap, 0);
        chk("mid_rst_busy", int'(busy0), 0);
        @(posedge CLK); #1;
        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(255));
        build_model();
        base = cnt0;
        send_frame(N, 20, 1'b0, fw);
        verify("after_rst", base, 1);

        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(255));
        build_model();
        base = cnt0;
        send_frame(N, 0, 1'b1, fw);
        send_frame(N, 0, 1'b0, fw);
        chk("b2b_ready_low", fw, W + 4);
        verify("b2b", base, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
        $fatal(1);
    end
endmodule
